pipe_wb_stage: RTL
==================

PIPE_WB_STAGE -- requirements
Module: pipe_wb_stage

Interface
REQ-001 Parameter XLEN, default 32, write-back data width in bits.
REQ-002 Parameter REG_AW, default 5, register-file address width.
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port flush  input  1  discard all held and incoming beats this cycle.
REQ-006 Port in_valid  input  1  upstream (MEM) beat present.
REQ-007 Port in_ready  output  1  stage can accept a beat; driven from a register.
REQ-008 Port rd_in  input  XLEN  write-back data.
REQ-009 Port rd_en_in  input  1  write-back enable.
REQ-010 Port rd_addr_in  input  REG_AW  destination register.
REQ-011 Port out_valid  output  1  beat presented to the register-file write port.
REQ-012 Port out_ready  input  1  downstream accepts the beat.
REQ-013 Port rd_out / rd_en_out / rd_addr_out  output  XLEN / 1 / REG_AW  head payload.
REQ-014 Port occupancy  output  2  held beats, 0..2.

Function
REQ-015 Accept = in_valid && in_ready; deliver = out_valid && out_ready; both evaluated on the same edge.
REQ-016 Two-entry skid buffer: head register drives outputs; skid register absorbs one beat after in_ready drops.
REQ-017 States EMPTY (occ 0), ONE (occ 1), TWO (occ 2); out_valid = (state != EMPTY).
REQ-018 EMPTY: accept -> ONE, head <= input.
REQ-019 ONE: accept && deliver -> ONE, head <= input; accept only -> TWO, skid <= input; deliver only -> EMPTY.
REQ-020 TWO: no accept possible; deliver -> ONE, head <= skid; otherwise hold.
REQ-021 in_ready register = (next state != TWO); a producer seeing in_ready=1 always has space.
REQ-022 Latency: beat accepted into EMPTY appears on outputs the next cycle; full throughput of 1 beat/cycle in ONE with out_ready=1.
REQ-023 Head payload and out_valid hold stable while out_valid && !out_ready.
REQ-024 x0 suppression: a beat with rd_addr_in == 0 is captured with rd_en forced to 0; data and addr kept.
REQ-025 flush: next state EMPTY, in_ready <= 1; any beat accepted in the flush cycle is dropped; flush overrides accept and deliver.
REQ-026 A deliver coinciding with flush still counts as delivered downstream (outputs were valid that cycle).
REQ-027 Beats leave in arrival order; no beat duplicated or lost except by flush.
REQ-028 Payload registers of an empty slot are don't-care internally but outputs show the last head value when out_valid=0.

Reset
REQ-029 On rst=1 at a clock edge: state EMPTY, out_valid 0, rd_out 0, rd_en_out 0, rd_addr_out 0, occupancy 0, in_ready 1.
REQ-030 rst has priority over flush, accept and deliver; reset mid-transfer drops all held beats.
REQ-031 No asynchronous reset path; outputs before the first reset edge are undefined.

Structure
REQ-032 XLEN, XREG_ADDRWIDTH, RST_ENABLE, FALSE and zero constants come from the shared config package; state encoding (EMPTY/ONE/TWO) is added there.
REQ-033 One sub-module, wb_slot: load-enabled payload register (data, en, addr) with sync reset, instantiated for head and skid.
REQ-034 Control FSM and in_ready register live in pipe_wb_stage itself.

Verification
REQ-035 Reset, then one beat rd_in=0x1234_5678, rd_en=1, addr=3, out_ready=1 -> next cycle out_valid=1 with same payload, occupancy 1, then 0.
REQ-036 Stream beats 1..8 with out_ready held 0 -> occupancy reaches 2, in_ready falls after second accept; release out_ready -> beats emerge in order 1..8, no gaps once streaming.
REQ-037 Beat with addr=0, rd_en=1, data=0xFFFF_FFFF -> output rd_en_out=0, rd_addr_out=0, rd_out=0xFFFF_FFFF.
REQ-038 Occupancy 2, assert flush together with in_valid and data 0xAA -> next cycle out_valid=0, occupancy 0, in_ready=1; 0xAA never appears.
REQ-039 Occupancy 2, assert rst for one cycle with flush and in_valid also high -> all outputs zero, in_ready=1, no beat emerges afterwards.
REQ-040 Randomised out_ready with continuous input, scoreboard compare -> zero loss, zero duplication, payload stable whenever out_valid && !out_ready.

Source files
------------

// File: rtl/pipe_wb_stage_pkg.sv
// rtl/pipe_wb_stage_pkg.sv - shared config constants and write-back stage state encoding
package pipe_wb_stage_pkg;

    localparam int XLEN           = 32;
    localparam int XREG_ADDRWIDTH = 5;

    localparam logic RST_ENABLE = 1'b1;
    localparam logic FALSE      = 1'b0;

    localparam logic [XLEN-1:0]           ZERO_DATA = '0;
    localparam logic [XREG_ADDRWIDTH-1:0] ZERO_ADDR = '0;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } wb_state_e;

endpackage

// File: rtl/pipe_wb_stage_if.sv
// rtl/pipe_wb_stage_if.sv - MEM-to-register-file write-back handshake bundle
interface pipe_wb_stage_if #(
    parameter int XLEN   = pipe_wb_stage_pkg::XLEN,
    parameter int REG_AW = pipe_wb_stage_pkg::XREG_ADDRWIDTH
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   rd_in;
    logic              rd_en_in;
    logic [REG_AW-1:0] rd_addr_in;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   rd_out;
    logic              rd_en_out;
    logic [REG_AW-1:0] rd_addr_out;
    logic [1:0]        occupancy;

    modport master (
        output flush, in_valid, rd_in, rd_en_in, rd_addr_in, out_ready,
        input  in_ready, out_valid, rd_out, rd_en_out, rd_addr_out, occupancy
    );

    modport slave (
        input  flush, in_valid, rd_in, rd_en_in, rd_addr_in, out_ready,
        output in_ready, out_valid, rd_out, rd_en_out, rd_addr_out, occupancy
    );
endinterface

// File: rtl/pipe_wb_stage_wb_slot.sv
// rtl/pipe_wb_stage_wb_slot.sv - load-enabled write-back payload register (data, en, addr)
module wb_slot #(
    parameter int XLEN   = pipe_wb_stage_pkg::XLEN,
    parameter int REG_AW = pipe_wb_stage_pkg::XREG_ADDRWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [XLEN-1:0]   d_data,
    input  logic              d_en,
    input  logic [REG_AW-1:0] d_addr,
    output logic [XLEN-1:0]   q_data,
    output logic              q_en,
    output logic [REG_AW-1:0] q_addr
);
    import pipe_wb_stage_pkg::*;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            q_data <= '0;
            q_en   <= FALSE;
            q_addr <= '0;
        end else if (load) begin
            q_data <= d_data;
            q_en   <= d_en;
            q_addr <= d_addr;
        end
    end
endmodule

// File: rtl/pipe_wb_stage.sv
// rtl/pipe_wb_stage.sv - two-entry skid buffer between MEM and the register-file write port
module pipe_wb_stage #(
    parameter int XLEN   = pipe_wb_stage_pkg::XLEN,
    parameter int REG_AW = pipe_wb_stage_pkg::XREG_ADDRWIDTH
) (
    input  logic           clk,
    input  logic           rst,
    pipe_wb_stage_if.slave bus
);
    import pipe_wb_stage_pkg::*;

    wb_state_e state, state_nxt;
    logic      in_ready_q, out_valid_q;
    logic      accept, deliver;
    logic      head_load, head_from_skid, skid_load;

    logic              in_en;
    logic [XLEN-1:0]   head_d_data, head_data, skid_data;
    logic              head_d_en, head_en, skid_en;
    logic [REG_AW-1:0] head_d_addr, head_addr, skid_addr;

    assign accept  = bus.in_valid && in_ready_q;
    assign deliver = out_valid_q && bus.out_ready;

    // Writes to x0 are kept as bubbles so ordering and data stay visible downstream.
    assign in_en = bus.rd_en_in && (bus.rd_addr_in != '0);

    always_comb begin
        state_nxt      = state;
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt = ST_ONE;
                    head_load = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && deliver) begin
                    head_load = 1'b1;
                end else if (accept) begin
                    state_nxt = ST_TWO;
                    skid_load = 1'b1;
                end else if (deliver) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (deliver) begin
                    state_nxt      = ST_ONE;
                    head_load      = 1'b1;
                    head_from_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // Flush drops everything; the head keeps its last value for display only.
        if (bus.flush) begin
            state_nxt = ST_EMPTY;
            head_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state       <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= FALSE;
        end else begin
            state       <= state_nxt;
            in_ready_q  <= (state_nxt != ST_TWO);
            out_valid_q <= (state_nxt != ST_EMPTY);
        end
    end

    assign head_d_data = head_from_skid ? skid_data : bus.rd_in;
    assign head_d_en   = head_from_skid ? skid_en   : in_en;
    assign head_d_addr = head_from_skid ? skid_addr : bus.rd_addr_in;

    wb_slot #(.XLEN(XLEN), .REG_AW(REG_AW)) u_head (
        .clk    (clk),
        .rst    (rst),
        .load   (head_load),
        .d_data (head_d_data),
        .d_en   (head_d_en),
        .d_addr (head_d_addr),
        .q_data (head_data),
        .q_en   (head_en),
        .q_addr (head_addr)
    );

    wb_slot #(.XLEN(XLEN), .REG_AW(REG_AW)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .d_data (bus.rd_in),
        .d_en   (in_en),
        .d_addr (bus.rd_addr_in),
        .q_data (skid_data),
        .q_en   (skid_en),
        .q_addr (skid_addr)
    );

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.rd_out      = head_data;
    assign bus.rd_en_out   = head_en;
    assign bus.rd_addr_out = head_addr;
    assign bus.occupancy   = state;
endmodule
